x9_sequencer: RTL and testbench

Multi-cycle run controller for the X9 core. It sequences fetch, execute and memory-wait cycles around the opcode decoder's control outputs, and owns the program counter, including branch redirection and halt. It gates register-file and data-memory strobes, and provides the Req/Ack start/done handshake plus cycle and instruction counters to the top level and testbench.

---
 rtl/x9_pkg.sv | 25 ++
 rtl/x9_sat_counter.sv | 27 ++
 rtl/x9_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_x9_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/x9_pkg.sv
// Shared definitions for the X9 core: sequencer state encoding and the
// default widths used by the sequencer, instruction ROM and top level.
package x9_pkg;

    // Default program-counter / instruction-address width.
    localparam int PCW_DEF  = 10;
    // Default width of the run performance counters.
    localparam int CNTW_DEF = 16;

    // Run-controller states. IDLE is the all-zero encoding so that a
    // freshly reset sequencer reads back as 0 on the debug state output.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    // True for the states in which a run is in progress.
    function automatic logic state_is_busy(input seq_state_t s);
        return (s == FETCH) || (s == EXEC) || (s == MEM);
    endfunction

endpackage

// File: rtl/x9_sat_counter.sv
// Saturating up-counter used for the retired-instruction and cycle
// counters. A synchronous clear wins over increment; once the count
// reaches all-ones it holds there until cleared or reset.
module x9_sat_counter
    import x9_pkg::*;
#(
    parameter int WIDTH = CNTW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Counter register: clear has priority, increment stops at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/x9_sequencer.sv
// X9 run controller. Steps each instruction through FETCH, EXEC and (for
// lb/sb) MEM, owns the program counter including branch redirection and
// the halt address, gates the register-file and data-memory strobes and
// provides the Req/Ack run handshake plus saturating run counters.
//
// Handshake: Req is only looked at in IDLE; an accepted Req loads PC from
// StartAddr and clears both counters. The run ends when the instruction at
// HaltAddr retires; the following cycle is DONE, where Ack is high for
// exactly one cycle, after which the controller is back in IDLE. Req seen
// while Busy or in DONE is dropped, not queued.
module x9_sequencer
    import x9_pkg::*;
#(
    parameter int PCW  = PCW_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Req,
    input  logic [PCW-1:0]  StartAddr,
    input  logic [PCW-1:0]  HaltAddr,
    input  logic            BranchInst,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic            RegWrite,
    input  logic            BranchTaken,
    input  logic [PCW-1:0]  BranchTarget,
    input  logic            MemReady,
    output logic [PCW-1:0]  PC,
    output logic            InstrValid,
    output logic            RegWriteEn,
    output logic            MemReq,
    output logic            MemWe,
    output logic            Busy,
    output logic            Ack,
    output logic [CNTW-1:0] InstrCount,
    output logic [CNTW-1:0] CycleCount,
    output logic [2:0]      dbg_state
);

    seq_state_t     state;
    seq_state_t     state_nxt;

    logic [PCW-1:0] pc_q;
    logic [PCW-1:0] pc_nxt;
    logic [PCW-1:0] pc_adv;

    // Memory-instruction flags captured in EXEC so MEM does not depend on
    // the decoder outputs staying stable while the access is pending.
    logic           mrd;
    logic           mwr;
    logic           rw;
    logic           latch_en;

    logic           retire;
    logic           cnt_clr;
    logic           mem_op;

    assign mem_op = MemRead | MemWrite;

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Program counter and latched memory-instruction flags.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q <= '0;
            mrd  <= 1'b0;
            mwr  <= 1'b0;
            rw   <= 1'b0;
        end else begin
            pc_q <= pc_nxt;
            if (latch_en) begin
                mrd <= MemRead;
                mwr <= MemWrite;
                rw  <= RegWrite;
            end
        end
    end

    // Next-state, PC update and per-state output decode.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc_q;
        pc_adv     = pc_q + 1'b1;
        latch_en   = 1'b0;
        retire     = 1'b0;
        cnt_clr    = 1'b0;
        InstrValid = 1'b0;
        RegWriteEn = 1'b0;
        MemReq     = 1'b0;
        MemWe      = 1'b0;
        Ack        = 1'b0;

        case (state)
            IDLE: begin
                if (Req) begin
                    pc_nxt    = StartAddr;
                    cnt_clr   = 1'b1;
                    state_nxt = FETCH;
                end
            end

            FETCH: begin
                InstrValid = 1'b1;
                state_nxt  = EXEC;
            end

            EXEC: begin
                if (mem_op) begin
                    latch_en  = 1'b1;
                    state_nxt = MEM;
                end else begin
                    retire     = 1'b1;
                    RegWriteEn = RegWrite;
                    if (BranchInst && BranchTaken) begin
                        pc_adv = BranchTarget;
                    end
                end
            end

            MEM: begin
                MemReq = 1'b1;
                MemWe  = mwr;
                if (MemReady) begin
                    retire = 1'b1;
                    // A combined read+write is treated as a store, so the
                    // register file is never written for it.
                    RegWriteEn = rw & mrd & ~mwr;
                end
            end

            DONE: begin
                Ack       = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Retiring the halt instruction freezes PC at HaltAddr and ends the
        // run; anything else moves on to the next fetch.
        if (retire) begin
            if (pc_q == HaltAddr) begin
                state_nxt = DONE;
            end else begin
                state_nxt = FETCH;
                pc_nxt    = pc_adv;
            end
        end
    end

    assign Busy      = state_is_busy(state);
    assign PC        = pc_q;
    assign dbg_state = state;

    x9_sat_counter #(
        .WIDTH (CNTW)
    ) u_instr_cnt (
        .clk   (Clk),
        .rst   (Reset),
        .clr   (cnt_clr),
        .inc   (retire),
        .count (InstrCount)
    );

    x9_sat_counter #(
        .WIDTH (CNTW)
    ) u_cycle_cnt (
        .clk   (Clk),
        .rst   (Reset),
        .clr   (cnt_clr),
        .inc   (Busy),
        .count (CycleCount)
    );

endmodule

// File: tb/tb_x9_sequencer.sv
// Bench for x9_sequencer. A small instruction ROM describes each test
// program; a run model walks the program at instruction level and emits the
// per-cycle input stimulus and the per-cycle expected outputs, which are
// compared against the DUT on every cycle of the run. Hand-computed totals
// (pulse counts, counter values at Ack, fetched PCs) pin the model.
module tb_x9_sequencer;
  import x9_pkg::*;

  localparam int PCW  = 10;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;
  localparam int PMOD = 1 << PCW;

  localparam int K_ALU  = 0;
  localparam int K_BR   = 1;
  localparam int K_LB   = 2;
  localparam int K_SB   = 3;
  localparam int K_LBSB = 4;

  // ---------------- clock / reset / DUT ----------------
  logic            Clk;
  logic            Reset;
  logic            Req;
  logic [PCW-1:0]  StartAddr;
  logic [PCW-1:0]  HaltAddr;
  logic            BranchInst;
  logic            MemRead;
  logic            MemWrite;
  logic            RegWrite;
  logic            BranchTaken;
  logic [PCW-1:0]  BranchTarget;
  logic            MemReady;
  logic [PCW-1:0]  PC;
  logic            InstrValid;
  logic            RegWriteEn;
  logic            MemReq;
  logic            MemWe;
  logic            Busy;
  logic            Ack;
  logic [CNTW-1:0] InstrCount;
  logic [CNTW-1:0] CycleCount;
  logic [2:0]      dbg_state;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  x9_sequencer #(.PCW(PCW), .CNTW(CNTW)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Req          (Req),
    .StartAddr    (StartAddr),
    .HaltAddr     (HaltAddr),
    .BranchInst   (BranchInst),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .RegWrite     (RegWrite),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .MemReady     (MemReady),
    .PC           (PC),
    .InstrValid   (InstrValid),
    .RegWriteEn   (RegWriteEn),
    .MemReq       (MemReq),
    .MemWe        (MemWe),
    .Busy         (Busy),
    .Ack          (Ack),
    .InstrCount   (InstrCount),
    .CycleCount   (CycleCount),
    .dbg_state    (dbg_state)
  );

  // ---------------- types, ROM, queues ----------------
  typedef struct packed {
    logic [PCW-1:0]  pc;
    logic            iv;
    logic            rwe;
    logic            mreq;
    logic            mwe;
    logic            busy;
    logic            ack;
    logic [CNTW-1:0] ic;
    logic [CNTW-1:0] cc;
  } obs_t;

  typedef struct packed {
    logic           req;
    logic           br;
    logic           mrd;
    logic           mwr;
    logic           rw;
    logic           tk;
    logic [PCW-1:0] tgt;
    logic           rdy;
  } stim_t;

  typedef struct {
    int kind;
    bit rw;
    bit taken;
    int target;
    int waits;
    bit noise;
  } instr_t;

  instr_t rom [0:PMOD-1];
  stim_t  stim_q[$];
  obs_t   exp_q[$];
  int     fetch_pcs[$];

  int errors = 0;
  int checks = 0;

  int rwe_pulses;
  int mreq_cycles;
  int mwe_cycles;
  int ack_count;
  int ack_ic;
  int ack_cc;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic obs_t mk_obs(input int pc, input bit iv, input bit rwe, input bit mreq,
                                  input bit mwe, input bit busy, input bit ack,
                                  input int ic, input int cc);
    obs_t o;
    o.pc   = pc[PCW-1:0];
    o.iv   = iv;
    o.rwe  = rwe;
    o.mreq = mreq;
    o.mwe  = mwe;
    o.busy = busy;
    o.ack  = ack;
    o.ic   = ic[CNTW-1:0];
    o.cc   = cc[CNTW-1:0];
    return o;
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < PMOD; i++) begin
      rom[i].kind   = K_ALU;
      rom[i].rw     = 1'b0;
      rom[i].taken  = 1'b0;
      rom[i].target = 0;
      rom[i].waits  = 0;
      rom[i].noise  = 1'b0;
    end
  endtask

  task automatic apply(input stim_t s);
    Req          = s.req;
    BranchInst   = s.br;
    MemRead      = s.mrd;
    MemWrite     = s.mwr;
    RegWrite     = s.rw;
    BranchTaken  = s.tk;
    BranchTarget = s.tgt;
    MemReady     = s.rdy;
  endtask

  // ---------------- run model ----------------
  // Walks the program instruction by instruction: FETCH, EXEC, then
  // waits+1 MEM cycles for memory ops. Produces stimulus and expectations.
  task automatic build_run(input int start, input int halt, input bit hold);
    int     pc, ic, cc, guard;
    bit     done, is_mem, is_rd, is_wr, last;
    instr_t in;
    stim_t  s;
    stim_q.delete();
    exp_q.delete();
    pc = start; ic = 0; cc = 0; guard = 0; done = 1'b0;
    while (!done && guard < 200) begin
      in    = rom[pc];
      is_rd = (in.kind == K_LB) || (in.kind == K_LBSB);
      is_wr = (in.kind == K_SB) || (in.kind == K_LBSB);
      is_mem = is_rd || is_wr;
      // fetch cycle; decoder not yet meaningful
      s = '0; s.req = hold; s.rdy = in.noise;
      stim_q.push_back(s);
      exp_q.push_back(mk_obs(pc, 1, 0, 0, 0, 1, 0, ic, cc));
      cc = sat(cc + 1);
      // execute cycle
      s = '0; s.req = hold; s.rdy = in.noise;
      s.br = (in.kind == K_BR); s.tk = in.taken; s.tgt = in.target[PCW-1:0];
      s.rw = in.rw; s.mrd = is_rd; s.mwr = is_wr;
      stim_q.push_back(s);
      exp_q.push_back(mk_obs(pc, 0, !is_mem && in.rw, 0, 0, 1, 0, ic, cc));
      cc = sat(cc + 1);
      if (is_mem) begin
        for (int w = 0; w <= in.waits; w++) begin
          last = (w == in.waits);
          s = '0; s.req = hold; s.rdy = last;
          stim_q.push_back(s);
          exp_q.push_back(mk_obs(pc, 0, last && in.rw && is_rd && !is_wr, 1, is_wr, 1, 0, ic, cc));
          cc = sat(cc + 1);
        end
      end
      ic = sat(ic + 1);
      if (pc == halt) done = 1'b1;
      else if (!is_mem && in.kind == K_BR && in.taken) pc = in.target;
      else pc = (pc + 1) % PMOD;
      guard++;
    end
    // DONE cycle, then one IDLE cycle
    s = '0; s.req = hold;
    stim_q.push_back(s);
    exp_q.push_back(mk_obs(halt, 0, 0, 0, 0, 0, 1, ic, cc));
    stim_q.push_back(s);
    exp_q.push_back(mk_obs(halt, 0, 0, 0, 0, 0, 0, ic, cc));
    if (hold) begin
      // Req still high in IDLE starts a fresh run
      stim_q.push_back(s);
      exp_q.push_back(mk_obs(start, 1, 0, 0, 0, 1, 0, 0, 0));
    end
  endtask

  // ---------------- driver + compare ----------------
  task automatic run_prog(input string tag, input int start, input int halt, input bit hold);
    stim_t s;
    obs_t  e, a;
    int    n;
    build_run(start, halt, hold);
    rwe_pulses = 0; mreq_cycles = 0; mwe_cycles = 0;
    ack_count = 0; ack_ic = -1; ack_cc = -1;
    fetch_pcs.delete();
    @(negedge Clk);
    s = '0; s.req = 1'b1;
    apply(s);
    StartAddr = start[PCW-1:0];
    HaltAddr  = halt[PCW-1:0];
    n = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge Clk);
      apply(s);
      #1;
      a = mk_obs(PC, InstrValid, RegWriteEn, MemReq, MemWe & e.mreq, Busy, Ack,
                 InstrCount, CycleCount);
      check($sformatf("%s_cycle%0d", tag, n), a, e);
      if (RegWriteEn) rwe_pulses++;
      if (MemReq) mreq_cycles++;
      if (MemReq && MemWe) mwe_cycles++;
      if (InstrValid) fetch_pcs.push_back(int'(PC));
      if (Ack) begin
        ack_count++;
        ack_ic = int'(InstrCount);
        ack_cc = int'(CycleCount);
      end
      n++;
    end
    s = '0;
    @(negedge Clk);
    apply(s);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    Reset = 1'b1;
    StartAddr = '0; HaltAddr = '0;
    apply('0);
    clear_rom();

    // reset state
    repeat (2) @(negedge Clk);
    #1;
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_pc", 64'(PC), 64'd0);
    check("rst_busy_ack", {Busy, Ack, InstrValid, MemReq, RegWriteEn}, 64'd0);
    check("rst_counts", {InstrCount, CycleCount}, 64'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // reset mid-MEM with MemReady low
    @(negedge Clk);
    Req = 1'b1; StartAddr = 10'd50; HaltAddr = 10'd50;
    @(negedge Clk);
    Req = 1'b0;                                   // FETCH
    @(negedge Clk);
    MemRead = 1'b1; RegWrite = 1'b1;              // EXEC: lb
    @(negedge Clk);
    MemRead = 1'b0; RegWrite = 1'b0; MemReady = 1'b0;
    #1;
    check("mid_memreq_before", 64'(MemReq), 64'd1);
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    check("mid_rst_memreq", 64'(MemReq), 64'd0);
    check("mid_rst_pc", 64'(PC), 64'd0);
    check("mid_rst_icnt", 64'(InstrCount), 64'd0);
    check("mid_rst_ack", 64'(Ack), 64'd0);
    repeat (2) begin
      @(negedge Clk);
      #1;
      check("mid_rst_hold_ack", 64'(Ack), 64'd0);
    end
    Reset = 1'b0;

    // three ALU ops 5..7 with RegWrite; stray MemReady/BranchTaken ignored
    clear_rom();
    for (int i = 5; i <= 7; i++) rom[i].rw = 1'b1;
    rom[5].noise = 1'b1;
    rom[6].taken = 1'b1; rom[6].target = 0;
    run_prog("alu", 5, 7, 1'b0);
    check("alu_rwe_pulses", 64'(rwe_pulses), 64'd3);
    check("alu_ack_count", 64'(ack_count), 64'd1);
    check("alu_ack_ic", 64'(ack_ic), 64'd3);
    check("alu_ack_cc", 64'(ack_cc), 64'd6);
    check("alu_fetch_last", 64'(fetch_pcs[2]), 64'd7);

    // lb at 2 with 4 wait cycles, then ALU at 3
    clear_rom();
    rom[2].kind = K_LB; rom[2].rw = 1'b1; rom[2].waits = 4; rom[2].noise = 1'b1;
    run_prog("lb", 2, 3, 1'b0);
    check("lb_memreq_cycles", 64'(mreq_cycles), 64'd5);
    check("lb_mwe_cycles", 64'(mwe_cycles), 64'd0);
    check("lb_rwe_pulses", 64'(rwe_pulses), 64'd1);
    check("lb_next_pc", 64'(fetch_pcs[1]), 64'd3);
    check("lb_ack_cc", 64'(ack_cc), 64'd9);

    // sb immediate ready, then combined rd+wr with RegWrite (store wins)
    clear_rom();
    rom[0].kind = K_SB;
    rom[1].kind = K_LBSB; rom[1].rw = 1'b1; rom[1].waits = 1;
    run_prog("sb", 0, 1, 1'b0);
    check("sb_memreq_cycles", 64'(mreq_cycles), 64'd3);
    check("sb_mwe_cycles", 64'(mwe_cycles), 64'd3);
    check("sb_rwe_pulses", 64'(rwe_pulses), 64'd0);
    check("sb_ack_cc", 64'(ack_cc), 64'd7);

    // beq taken at 10 -> 3
    clear_rom();
    rom[10].kind = K_BR; rom[10].taken = 1'b1; rom[10].target = 3;
    rom[3].rw = 1'b1;
    run_prog("br_tk", 10, 3, 1'b0);
    check("br_tk_next_pc", 64'(fetch_pcs[1]), 64'd3);
    check("br_tk_ack_cc", 64'(ack_cc), 64'd4);

    // same beq not taken -> 11
    rom[10].taken = 1'b0;
    run_prog("br_nt", 10, 11, 1'b0);
    check("br_nt_next_pc", 64'(fetch_pcs[1]), 64'd11);

    // PC wraps 1023 -> 0
    clear_rom();
    run_prog("wrap", 1023, 0, 1'b0);
    check("wrap_next_pc", 64'(fetch_pcs[1]), 64'd0);
    check("wrap_ack_ic", 64'(ack_ic), 64'd2);

    // Req held through a 20-instruction run; counters saturate at 15
    clear_rom();
    for (int i = 100; i < 120; i++) rom[i].rw = i[0];
    run_prog("hold", 100, 119, 1'b1);
    check("hold_ack_count", 64'(ack_count), 64'd1);
    check("hold_ack_ic", 64'(ack_ic), 64'd15);
    check("hold_ack_cc", 64'(ack_cc), 64'd15);
    check("hold_rwe_pulses", 64'(rwe_pulses), 64'd10);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
